// File: rtl/up_down_mod_counter_if.sv
// Control and status bundle for up_down_mod_counter.
interface up_down_mod_counter_if #(
   parameter int unsigned BITS = 8
);
   logic            clear;
   logic            load;
   logic [BITS-1:0] D;
   logic            enable;
   logic            up;
   logic            sat;
   logic [BITS-1:0] step;
   logic [BITS-1:0] max_val;
   logic [BITS-1:0] Q;
   logic            tc;
   logic            wrap;
   logic            err;

   modport master (
      output clear, load, D, enable, up, sat, step, max_val,
      input  Q, tc, wrap, err
   );

   modport slave (
      input  clear, load, D, enable, up, sat, step, max_val,
      output Q, tc, wrap, err
   );
endinterface

// File: rtl/up_down_mod_counter.sv
// Modulo-N up/down counter with parallel load, variable step,
// wrap/saturate mode, terminal-count flag and wrap/error pulses.
module up_down_mod_counter #(
   parameter int unsigned BITS = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   up_down_mod_counter_if.slave     bus
);
   localparam int unsigned W1 = BITS + 1;

   logic [BITS-1:0] r_q;
   logic            r_wrap;
   logic            r_err;

   logic [BITS-1:0] w_q_nxt;
   logic            w_wrap_nxt;
   logic            w_err_nxt;

   logic [W1-1:0]   w_q_ext;
   logic [W1-1:0]   w_step_ext;
   logic [W1-1:0]   w_max_ext;
   logic [W1-1:0]   w_sum;
   logic [W1-1:0]   w_up_wrap;
   logic [W1-1:0]   w_dn_wrap;
   logic            w_step_oor;
   logic            w_q_oor;

   // Extended arithmetic shared by the count paths.
   assign w_q_ext    = {1'b0, r_q};
   assign w_step_ext = {1'b0, bus.step};
   assign w_max_ext  = {1'b0, bus.max_val};
   assign w_sum      = w_q_ext + w_step_ext;
   assign w_up_wrap  = w_sum - (w_max_ext + W1'(1));
   assign w_dn_wrap  = w_q_ext + w_max_ext + W1'(1) - w_step_ext;

   // A step larger than the range is an error, except step=1 on a
   // single-value range, which is a legal full-cycle step that wraps.
   assign w_step_oor = (bus.step > bus.max_val) &&
                       !((bus.max_val == '0) && (bus.step == BITS'(1)));
   assign w_q_oor    = (r_q > bus.max_val);

   // Next count, wrap and error selection in priority order.
   always_comb begin
      w_q_nxt    = r_q;
      w_wrap_nxt = 1'b0;
      w_err_nxt  = 1'b0;
      if (bus.clear) begin
         w_q_nxt = '0;
      end else if (bus.load) begin
         if (bus.D > bus.max_val) begin
            w_q_nxt   = bus.max_val;
            w_err_nxt = 1'b1;
         end else begin
            w_q_nxt = bus.D;
         end
      end else if (bus.enable) begin
         if (bus.step == '0) begin
            w_q_nxt = r_q;
         end else if (w_step_oor) begin
            w_q_nxt   = bus.up ? '0 : bus.max_val;
            w_err_nxt = 1'b1;
         end else if (w_q_oor) begin
            w_q_nxt   = (bus.up && !bus.sat) ? '0 : bus.max_val;
            w_err_nxt = 1'b1;
         end else if (bus.up) begin
            if (w_sum <= w_max_ext) begin
               w_q_nxt = BITS'(w_sum);
            end else if (!bus.sat) begin
               w_q_nxt    = BITS'(w_up_wrap);
               w_wrap_nxt = 1'b1;
            end else begin
               w_q_nxt    = bus.max_val;
               w_wrap_nxt = (r_q != bus.max_val);
            end
         end else begin
            if (r_q >= bus.step) begin
               w_q_nxt = r_q - bus.step;
            end else if (!bus.sat) begin
               w_q_nxt    = BITS'(w_dn_wrap);
               w_wrap_nxt = 1'b1;
            end else begin
               w_q_nxt    = '0;
               w_wrap_nxt = (r_q != '0);
            end
         end
      end
   end

   // Count and pulse registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_q    <= '0;
         r_wrap <= 1'b0;
         r_err  <= 1'b0;
      end else begin
         r_q    <= w_q_nxt;
         r_wrap <= w_wrap_nxt;
         r_err  <= w_err_nxt;
      end
   end

   assign bus.Q    = r_q;
   assign bus.wrap = r_wrap;
   assign bus.err  = r_err;
   // Terminal count follows up and max_val without waiting for a clock.
   assign bus.tc   = bus.up ? (r_q == bus.max_val) : (r_q == '0);
endmodule

// File: tb/tb_up_down_mod_counter.sv
// Directed bench for up_down_mod_counter with hand-computed expectations.
module tb_up_down_mod_counter;
   localparam int unsigned BITS = 8;

   logic clk;
   logic reset;
   int   n_total;
   int   n_bad;

   up_down_mod_counter_if #(.BITS(BITS)) bus ();

   up_down_mod_counter #(.BITS(BITS)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count one comparison and report a mismatch.
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_out(input string tag, input int q, input int w, input int e);
      chk({tag, ".Q"},    32'(bus.Q),    32'(q));
      chk({tag, ".wrap"}, 32'(bus.wrap), 32'(w));
      chk({tag, ".err"},  32'(bus.err),  32'(e));
   endtask

   int exp_q1  [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
   int exp_q2  [4]  = '{4, 1, 8, 5};
   int exp_w2  [4]  = '{0, 0, 1, 0};

   initial begin
      n_total = 0;
      n_bad   = 0;
      reset       = 1'b1;
      bus.clear   = 1'b0;
      bus.load    = 1'b0;
      bus.D       = '0;
      bus.enable  = 1'b0;
      bus.up      = 1'b1;
      bus.sat     = 1'b0;
      bus.step    = 8'd1;
      bus.max_val = 8'd9;
      #12;
      chk_out("rst", 0, 0, 0);
      chk("rst.tc_up", 32'(bus.tc), 32'd0);
      bus.up = 1'b0;
      #1;
      chk("rst.tc_dn", 32'(bus.tc), 32'd1);
      bus.up = 1'b1;
      tick();
      reset = 1'b0;

      // Wrap-mode count up through modulus 10.
      bus.enable = 1'b1;
      for (int i = 0; i < 12; i++) begin
         tick();
         chk_out($sformatf("up9[%0d]", i), exp_q1[i], (i == 9) ? 1 : 0, 0);
         chk($sformatf("up9.tc[%0d]", i), 32'(bus.tc), (exp_q1[i] == 9) ? 32'd1 : 32'd0);
      end

      // Load 7 then count down by 3 with wrap.
      bus.enable = 1'b0;
      bus.load   = 1'b1;
      bus.D      = 8'd7;
      tick();
      chk_out("ld7", 7, 0, 0);
      bus.load   = 1'b0;
      bus.enable = 1'b1;
      bus.up     = 1'b0;
      bus.step   = 8'd3;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk_out($sformatf("dn3[%0d]", i), exp_q2[i], exp_w2[i], 0);
      end

      // Saturate mode, up by 4 under max 15.
      bus.enable  = 1'b0;
      bus.max_val = 8'd15;
      bus.load    = 1'b1;
      bus.D       = 8'd10;
      tick();
      bus.load    = 1'b0;
      bus.enable  = 1'b1;
      bus.up      = 1'b1;
      bus.sat     = 1'b1;
      bus.step    = 8'd4;
      tick();
      chk_out("sat14", 14, 0, 0);
      tick();
      chk_out("sat15a", 15, 1, 0);
      tick();
      chk_out("sat15b", 15, 0, 0);
      bus.enable = 1'b0;
      bus.load   = 1'b1;
      bus.D      = 8'd2;
      tick();
      bus.load   = 1'b0;
      bus.enable = 1'b1;
      bus.up     = 1'b0;
      tick();
      chk_out("sat0", 0, 1, 0);
      chk("sat0.tc", 32'(bus.tc), 32'd1);

      // Load above range clamps and flags err for one cycle.
      bus.enable  = 1'b0;
      bus.sat     = 1'b0;
      bus.max_val = 8'd9;
      bus.load    = 1'b1;
      bus.D       = 8'd12;
      tick();
      chk_out("ld12", 9, 0, 1);
      bus.load = 1'b0;
      tick();
      chk_out("ld12.idle", 9, 0, 0);
      bus.enable = 1'b1;
      bus.up     = 1'b1;
      bus.step   = 8'd10;
      tick();
      chk_out("step10", 0, 0, 1);

      // Zero step holds.
      bus.enable = 1'b0;
      bus.load   = 1'b1;
      bus.D      = 8'd5;
      tick();
      bus.load   = 1'b0;
      bus.enable = 1'b1;
      bus.step   = 8'd0;
      tick();
      chk_out("step0", 5, 0, 0);

      // Lowered max_val below the current count.
      bus.enable = 1'b0;
      bus.load   = 1'b1;
      bus.D      = 8'd8;
      tick();
      bus.load    = 1'b0;
      bus.max_val = 8'd8;
      #1;
      chk("tc.comb", 32'(bus.tc), 32'd1);
      bus.max_val = 8'd5;
      bus.step    = 8'd1;
      bus.enable  = 1'b1;
      tick();
      chk_out("qoor", 0, 0, 1);

      // Asynchronous reset mid-cycle.
      bus.enable  = 1'b0;
      bus.max_val = 8'd9;
      bus.load    = 1'b1;
      bus.D       = 8'd4;
      tick();
      chk_out("ld4", 4, 0, 0);
      bus.load = 1'b0;
      #2;
      reset = 1'b1;
      #1;
      chk_out("arst", 0, 0, 0);
      reset = 1'b0;

      // Clear beats load, load beats enable.
      tick();
      bus.load = 1'b1;
      bus.D    = 8'd5;
      tick();
      chk_out("ld5", 5, 0, 0);
      bus.clear  = 1'b1;
      bus.D      = 8'd7;
      bus.enable = 1'b1;
      tick();
      chk_out("clr", 0, 0, 0);
      bus.clear = 1'b0;
      bus.up    = 1'b0;
      bus.D     = 8'd3;
      tick();
      chk_out("ld_en", 3, 0, 0);

      // Single-value range: every step of 1 wraps.
      bus.load   = 1'b0;
      bus.enable = 1'b0;
      bus.clear  = 1'b1;
      tick();
      bus.clear   = 1'b0;
      bus.max_val = 8'd0;
      bus.up      = 1'b1;
      bus.enable  = 1'b1;
      tick();
      chk_out("m0a", 0, 1, 0);
      tick();
      chk_out("m0b", 0, 1, 0);
      chk("m0.tc", 32'(bus.tc), 32'd1);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule

// File: doc/up_down_mod_counter.md
# up_down_mod_counter

Parametrised up/down counter with synchronous parallel load, a runtime-programmable modulus and a selectable wrap/saturate mode. It generalises the fixed-width loadable up/down counter: it adds a variable step size, a terminal-count flag, and registered wrap and error indications. It serves as the timing and index generator for datapath blocks that need a modulo-N sequence without a dedicated counter per N.

## Interface
- BITS, 8, width of count, load value, limit and step
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high; forces all registers to reset values
- clear  input  1  synchronous clear to 0 (priority below reset)
- load  input  1  synchronous parallel load of D
- D  input  BITS  load value
- enable  input  1  count enable
- up  input  1  1 = count up, 0 = count down
- sat  input  1  0 = wrap mode, 1 = saturate mode
- step  input  BITS  increment/decrement magnitude per enabled cycle
- max_val  input  BITS  upper limit; count range is 0..max_val inclusive
- Q  output  BITS  current count (registered)
- tc  output  1  terminal count, combinational from Q
- wrap  output  1  registered one-cycle pulse on wrap or saturation hit
- err  output  1  registered one-cycle pulse on an out-of-range event

## Operation
- Priority per rising edge: reset > clear > load > enable count > hold.
- clear: Q=0, wrap=0, err=0.
- load: Q=D if D<=max_val; otherwise Q=max_val and err=1. load ignores enable, up and step.
- Enabled count, up=1, computed in BITS+1 bits as s=Q+step:
  - s<=max_val: Q=s.
  - s>max_val, wrap: Q=s-(max_val+1), wrap=1.
  - s>max_val, saturate: Q=max_val; wrap=1 only if Q was not already max_val.
- Enabled count, up=0:
  - Q>=step: Q=Q-step.
  - Q<step, wrap: Q=Q+(max_val+1)-step (BITS+1 arithmetic), wrap=1.
  - Q<step, saturate: Q=0; wrap=1 only if Q was not already 0.
- step=0 with enable: Q holds, wrap=0, err=0.
- step>max_val with enable (out of range): Q=0 if up=1, Q=max_val if up=0; err=1; wrap=0.
- Q>max_val at an enabled count (max_val lowered at runtime): Q=0 if up=1 and sat=0, otherwise Q=max_val; err=1.
- Idle cycles (no clear, load or enable) hold Q. wrap and err return to 0 on every edge that does not set them.
- tc=1 when up=1 and Q==max_val, or when up=0 and Q==0. It is combinational, so changing up, or changing max_val while counting up, updates it without a clock edge.
- max_val=0 is legal: Q stays 0; every enabled count with step=1 pulses wrap (wrap mode).

## Timing
- Reset (asynchronous assert): Q=0, wrap=0, err=0. Resulting tc is 1 if up=0, and 1 if up=1 and max_val=0.
- Reset release is registered on the next rising edge. The first operation occurs on the first rising edge with reset low.
- Latency: one cycle from a sampled control to the new Q, wrap and err. All inputs are sampled on the rising clk edge.
- Reset asserted mid-count: Q clears immediately, with no clock edge needed. Any pending wrap or err is discarded.
- Simultaneous load and enable: load wins, and no wrap pulse is produced.
- Simultaneous clear and load: clear wins.
- The wrap pulse is coincident with the edge that stores the wrapped Q. It is never stretched across cycles.

## Test plan
- Reset, then up=1, sat=0, step=1, max_val=9, enable for 12 cycles -> Q 1..9, 0, 1, 2; wrap high only in the cycle Q becomes 0; tc high while Q=9.
- Load D=7 with max_val=9, then up=0, step=3, wrap mode -> Q 7, 4, 1, 8 (wrap=1), 5.
- Saturate mode: max_val=15, step=4, up=1 from Q=10 -> Q 14, 15 (wrap=1), 15 (wrap=0). Then up=0 from Q=2 with step=4 -> Q 0 (wrap=1).
- Load D=12 with max_val=9 -> Q=9, err=1 for exactly one cycle. Then step=10, up=1, enable -> Q=0, err=1.
- Q=8 counting up, drop max_val to 5 in wrap mode -> next enabled edge gives Q=0, err=1. Asynchronous reset pulse mid-cycle -> Q=0 before the next edge.
- Load, clear and enable asserted in the same cycle with Q=5 -> Q=0, wrap=0. Load and enable together with D=3 -> Q=3, wrap=0.
